rr_arbiter_n: RTL and testbench

//  N-requester bus arbiter, parametrised successor to the 2-requester arbiter.
//  - Selects between fixed-priority and round-robin policy.
//  - Holds a grant while the owner keeps its request high.
//  - Bounds bus ownership with a hold timeout so no requester can starve others.
//  - Sits between the requesting agents and the shared resource; grant is registered.

---
 rtl/rr_arbiter_n.sv | 187 ++++++++++++++++++
 tb/tb_rr_arbiter_n.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n
//   N-requester bus arbiter with selectable fixed-priority or round-robin
//   policy, grant hold while the owner keeps requesting, and a hold-limit
//   timeout that hands the bus to a waiting requester.
//
// Parameters
//   N_REQ     number of requesters (2..16)
//   RR_MODE   1 = round-robin, 0 = fixed priority (lowest index wins)
//   MAX_HOLD  max consecutive grant cycles while others wait; 0 = unlimited
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   request      per-agent request, level-sensitive
//   grant        one-hot grant, registered
//   grant_valid  |grant, registered
//   grant_id     index of current owner (0 when idle), registered
//   timeout      1-cycle pulse: grant was revoked by the hold limit
//   dbg_state    current FSM state (0 = IDLE, 1 = OWNED)
//
// Handshake: an agent raises request and keeps it high until it sees its
// grant bit; it owns the resource for every cycle its grant bit is high and
// releases by dropping request. The arbiter samples request at each rising
// edge; the grant decided at that edge is visible in the following cycle.
// An agent must also accept losing its grant early when timeout pulses.
module rr_arbiter_n #(
  parameter int N_REQ    = 4,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         request,
  output logic [N_REQ-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     timeout,
  output logic [0:0]               dbg_state
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [HW-1:0] HOLD_LAST = HOLD_LAST_I[HW-1:0];
  localparam int PTR_RST_I = N_REQ - 1;
  localparam logic [IW-1:0] PTR_RST = PTR_RST_I[IW-1:0];

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             gv_q, gv_d;
  logic [IW-1:0]    id_q, id_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic             to_q, to_d;

  logic             any_req;
  logic             owner_req;
  logic             others_req;
  logic             expiry;
  logic             new_grant;
  logic [N_REQ-1:0] elig;
  logic [IW-1:0]    win;

  // Winner among the set bits of v. Round-robin starts the search one past
  // the last owner and wraps; fixed priority takes the lowest set index.
  // Callers only use the result when v is non-zero.
  function automatic logic [IW-1:0] pick(input logic [N_REQ-1:0] v,
                                         input logic [IW-1:0]    ptr);
    logic [IW-1:0] r;
    logic          found;
    int            idx;
    r     = '0;
    found = 1'b0;
    idx   = 0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx = (int'(ptr) + k) % N_REQ;
        if (!found && v[idx]) begin
          r     = idx[IW-1:0];
          found = 1'b1;
        end
      end
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (v[i]) r = i[IW-1:0];
      end
    end
    return r;
  endfunction

  always_comb begin
    any_req    = |request;
    owner_req  = |(request & grant_q);
    others_req = |(request & ~grant_q);
    // The hold limit only bites when someone else is actually waiting;
    // a lone owner keeps the bus with its counter saturated.
    expiry     = (MAX_HOLD > 0) && (state_q == OWNED) && owner_req &&
                 (hold_q == HOLD_LAST) && others_req;
    elig       = expiry ? (request & ~grant_q) : request;
    win        = pick(elig, ptr_q);
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gv_d      = gv_q;
    id_d      = id_q;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
    to_d      = 1'b0;
    new_grant = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) new_grant = 1'b1;
      end
      OWNED: begin
        if (expiry) begin
          new_grant = 1'b1;
          to_d      = 1'b1;
        end else if (owner_req) begin
          if ((MAX_HOLD > 0) && (hold_q != HOLD_LAST)) hold_d = hold_q + HW'(1);
        end else if (any_req) begin
          // Owner released with others pending: hand over on this same edge.
          new_grant = 1'b1;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          gv_d    = 1'b0;
          id_d    = '0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        gv_d    = 1'b0;
        id_d    = '0;
        hold_d  = '0;
      end
    endcase

    if (new_grant) begin
      state_d = OWNED;
      grant_d = '0;
      for (int i = 0; i < N_REQ; i++) begin
        if (win == i[IW-1:0]) grant_d[i] = 1'b1;
      end
      gv_d   = 1'b1;
      id_d   = win;
      hold_d = '0;
      ptr_d  = win;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gv_q    <= 1'b0;
      id_q    <= '0;
      hold_q  <= '0;
      ptr_q   <= PTR_RST;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gv_q    <= gv_d;
      id_q    <= id_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      to_q    <= to_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = gv_q;
  assign grant_id    = id_q;
  assign timeout     = to_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb_rr_arbiter_n
//   Directed bench for rr_arbiter_n. Three instances cover the parameter
//   corners: (a) round-robin, unlimited hold; (b) fixed priority, hold 8;
//   (c) round-robin, hold 8. The driver applies one request vector per edge
//   and pushes the hand-computed response; a negedge monitor pops and
//   compares against the instance tagged in the entry.
module tb_rr_arbiter_n;

  logic       clk;
  logic       reset;
  logic [3:0] req_w     [3];
  logic [3:0] grant_w   [3];
  logic       gv_w      [3];
  logic [1:0] id_w      [3];
  logic       to_w      [3];
  logic [0:0] st_w      [3];

  // Entry: {dut[1:0], state, grant[3:0], timeout, grant_valid, grant_id[1:0]}
  logic [10:0] exp_q[$];
  logic [1:0]  cur;
  int          n_checks;
  int          n_errors;

  rr_arbiter_n #(.N_REQ(4), .RR_MODE(1), .MAX_HOLD(0)) dut_a (
    .clk(clk), .reset(reset), .request(req_w[0]), .grant(grant_w[0]),
    .grant_valid(gv_w[0]), .grant_id(id_w[0]), .timeout(to_w[0]),
    .dbg_state(st_w[0]));

  rr_arbiter_n #(.N_REQ(4), .RR_MODE(0), .MAX_HOLD(8)) dut_b (
    .clk(clk), .reset(reset), .request(req_w[1]), .grant(grant_w[1]),
    .grant_valid(gv_w[1]), .grant_id(id_w[1]), .timeout(to_w[1]),
    .dbg_state(st_w[1]));

  rr_arbiter_n #(.N_REQ(4), .RR_MODE(1), .MAX_HOLD(8)) dut_c (
    .clk(clk), .reset(reset), .request(req_w[2]), .grant(grant_w[2]),
    .grant_valid(gv_w[2]), .grant_id(id_w[2]), .timeout(to_w[2]),
    .dbg_state(st_w[2]));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [1:0] oh2idx(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i[1:0];
    return r;
  endfunction

  function automatic logic [8:0] observe(input logic [1:0] d);
    return {st_w[d], grant_w[d], to_w[d], gv_w[d], id_w[d]};
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Applies v to the current instance for one edge and records the outputs
  // that edge must produce.
  task automatic drive(input logic [3:0] v, input logic [3:0] eg,
                       input logic et);
    for (int i = 0; i < 3; i++) req_w[i] = (i == int'(cur)) ? v : 4'b0000;
    @(posedge clk);
    #1;
    exp_q.push_back({cur, |eg, eg, et, |eg, oh2idx(eg)});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [10:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("dut%0d {st,grant,to,gv,id}", e[10:9]),
            16'(observe(e[10:9])), 16'(e[8:0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    cur      = 2'd0;
    for (int i = 0; i < 3; i++) req_w[i] = 4'b0000;
    reset = 1'b0;
    #7;
    for (int d = 0; d < 3; d++)
      check($sformatf("reset dut%0d outputs", d), 16'(observe(d[1:0])), 16'h0000);
    @(posedge clk);
    #2;
    reset = 1'b1;

    // --- dut_a: round-robin, unlimited hold ---
    cur = 2'd0;
    drive(4'b0100, 4'b0100, 1'b0);  // single request, 1-cycle latency
    drive(4'b0000, 4'b0000, 1'b0);  // release, nothing pending
    drive(4'b1000, 4'b1000, 1'b0);  // puts rr_ptr at 3
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b1111, 4'b0001, 1'b0);  // rotation 0,1,2,3,0
    drive(4'b1110, 4'b0010, 1'b0);
    drive(4'b1101, 4'b0100, 1'b0);
    drive(4'b1011, 4'b1000, 1'b0);
    drive(4'b0111, 4'b0001, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    // rr_ptr=0 so requester 1 wins; no hold limit, so it keeps the bus
    for (int i = 0; i < 12; i++) drive(4'b0011, 4'b0010, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);

    // --- dut_b: fixed priority, hold 8 ---
    cur = 2'd1;
    drive(4'b1010, 4'b0010, 1'b0);
    drive(4'b1000, 4'b1000, 1'b0);  // direct handover, no idle bubble
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b1111, 4'b0001, 1'b0);
    drive(4'b1110, 4'b0010, 1'b0);  // lowest remaining index
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0011, 4'b0001, 1'b0);  // expiry exclusion in fixed mode
    for (int i = 0; i < 7; i++) drive(4'b0011, 4'b0001, 1'b0);
    drive(4'b0011, 4'b0010, 1'b1);
    drive(4'b0011, 4'b0010, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);

    // --- dut_c: round-robin, hold 8 ---
    cur = 2'd2;
    drive(4'b0001, 4'b0001, 1'b0);
    for (int i = 0; i < 7; i++) drive(4'b0101, 4'b0001, 1'b0);
    drive(4'b0101, 4'b0100, 1'b1);  // 8 cycles of grant0, then revoke
    drive(4'b0101, 4'b0100, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) drive(4'b0010, 4'b0010, 1'b0);  // lone owner
    drive(4'b0000, 4'b0000, 1'b0);

    // --- asynchronous reset mid-grant ---
    drive(4'b0100, 4'b0100, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async reset dut2 outputs", 16'(observe(2'd2)), 16'h0000);
    for (int i = 0; i < 3; i++) req_w[i] = 4'b0000;
    #3;
    reset = 1'b1;
    drive(4'b1000, 4'b1000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);

    repeat (2) @(posedge clk);
    check("scoreboard drained", 16'(exp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
